// File: rtl/estagio_leitura_operandos.sv
// Operand-read stage: drives the bank read ports and captures operands into a
// valid/ready pipeline register. Define BYPASS_ESCRITA_EN for writeback bypass.
module estagio_leitura_operandos #(
    parameter int BITS = 63
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          entrada_valida,
    output logic          entrada_pronta,
    input  logic [4:0]    endereco_reg1,
    input  logic [4:0]    endereco_reg2,
    input  logic [4:0]    endereco_regd,
    input  logic          escreve_regd,
    output logic [4:0]    leitura_reg1,
    output logic [4:0]    leitura_reg2,
    input  logic [BITS:0] valor_reg1,
    input  logic [BITS:0] valor_reg2,
    input  logic          wb_permisao_escrita,
    input  logic [4:0]    wb_endereco_regd,
    input  logic [BITS:0] wb_dado_escrita,
    input  logic          descarta,
    output logic          saida_valida,
    input  logic          saida_pronta,
    output logic [BITS:0] operando1,
    output logic [BITS:0] operando2,
    output logic [4:0]    saida_regd,
    output logic          saida_escreve
);
    logic [4:0]    fonte1;
    logic [4:0]    fonte2;
    logic          captura;
    logic          segura;
    logic [BITS:0] sel1;
    logic [BITS:0] sel2;

    assign entrada_pronta = !saida_valida || saida_pronta;
    assign captura = entrada_valida && entrada_pronta && !descarta;
    assign segura = saida_valida && !saida_pronta;
    assign leitura_reg1 = endereco_reg1;
    assign leitura_reg2 = endereco_reg2;

`ifdef BYPASS_ESCRITA_EN
    logic byp1;
    logic byp2;
    logic upd1;
    logic upd2;

    assign byp1 = wb_permisao_escrita && (wb_endereco_regd == endereco_reg1);
    assign byp2 = wb_permisao_escrita && (wb_endereco_regd == endereco_reg2);
    assign upd1 = wb_permisao_escrita && (wb_endereco_regd == fonte1)
                  && (fonte1 != 5'd0);
    assign upd2 = wb_permisao_escrita && (wb_endereco_regd == fonte2)
                  && (fonte2 != 5'd0);
`else
    // Writeback and held sources only matter when the bypass exists.
    logic unused_wb;
    assign unused_wb = ^{wb_permisao_escrita, wb_endereco_regd,
                         wb_dado_escrita, fonte1, fonte2};
`endif

    // Capture-time operand select: x0 reads zero, else bypass, else bank.
    always_comb begin
        sel1 = valor_reg1;
        sel2 = valor_reg2;
`ifdef BYPASS_ESCRITA_EN
        if (byp1) sel1 = wb_dado_escrita;
        if (byp2) sel2 = wb_dado_escrita;
`endif
        if (endereco_reg1 == 5'd0) sel1 = '0;
        if (endereco_reg2 == 5'd0) sel2 = '0;
    end

    // Pipeline register: flush beats capture, capture beats hold/drain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            saida_valida  <= 1'b0;
            operando1     <= '0;
            operando2     <= '0;
            saida_regd    <= 5'd0;
            saida_escreve <= 1'b0;
            fonte1        <= 5'd0;
            fonte2        <= 5'd0;
        end else if (descarta) begin
            saida_valida <= 1'b0;
        end else if (captura) begin
            saida_valida  <= 1'b1;
            fonte1        <= endereco_reg1;
            fonte2        <= endereco_reg2;
            saida_regd    <= endereco_regd;
            saida_escreve <= escreve_regd;
            operando1     <= sel1;
            operando2     <= sel2;
        end else if (segura) begin
`ifdef BYPASS_ESCRITA_EN
            if (upd1) operando1 <= wb_dado_escrita;
            if (upd2) operando2 <= wb_dado_escrita;
`endif
        end else begin
            saida_valida <= 1'b0;
        end
    end
endmodule

// File: doc/estagio_leitura_operandos.md
# estagio_leitura_operandos

Operand-read pipeline stage sitting directly downstream of the 32×64-bit register bank (`banco_reg`). It forwards the decoder's source addresses to the bank's read ports and captures the returned operands, with a same-cycle writeback bypass, into a valid/ready-handshaked pipeline register. Its outputs feed the execute stage.

## Interface
- `BITS`, 63: MSB index of data words; the data width is `BITS+1`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `entrada_valida`  in  1  the decoder presents an instruction.
- `entrada_pronta`  out  1  the stage accepts this cycle.
- `endereco_reg1`, `endereco_reg2`  in  5  source register addresses from the decoder.
- `endereco_regd`  in  5  destination address of the instruction.
- `escreve_regd`  in  1  the instruction writes `endereco_regd`.
- `leitura_reg1`, `leitura_reg2`  out  5  drive the bank read ports; combinational copies of `endereco_reg1/2`.
- `valor_reg1`, `valor_reg2`  in  BITS+1  data returned by the bank.
- `wb_permisao_escrita`  in  1  the writeback write enable, the same net that drives the bank.
- `wb_endereco_regd`  in  5  the writeback address.
- `wb_dado_escrita`  in  BITS+1  the writeback data.
- `descarta`  in  1  flush; kills the held instruction.
- `saida_valida`  out  1  the operands are valid for execute.
- `saida_pronta`  in  1  the execute stage accepts.
- `operando1`, `operando2`  out  BITS+1  captured operands.
- `saida_regd`  out  5  registered `endereco_regd`.
- `saida_escreve`  out  1  registered `escreve_regd`.

## Operation
- Single-entry pipeline register plus held source addresses `fonte1` and `fonte2`, which are internal.
- `entrada_pronta = !saida_valida || saida_pronta`. This path is combinational. There is no skid buffer.
- Capture occurs when `entrada_valida && entrada_pronta && !descarta`:
  - `saida_valida` is set to 1.
  - `fonte1` and `fonte2` latch the source addresses.
  - `saida_regd` and `saida_escreve` latch the destination fields.
  - Each operand is loaded with the value selected below.
- Operand select for source N:
  - If the address is 0, the operand is 0.
  - Otherwise, if `wb_permisao_escrita && wb_endereco_regd == endereco_regN`, the operand is `wb_dado_escrita`.
  - Otherwise, the operand is `valor_regN`.
- Hold: when `saida_valida && !saida_pronta`, all outputs stay stable, with one exception. A writeback with `wb_endereco_regd == fonteN != 0` replaces `operandoN` with `wb_dado_escrita`. Two writebacks to the same address in consecutive hold cycles therefore leave the last value in the operand.
- Drain: when `saida_valida && saida_pronta` with no new capture, `saida_valida` goes to 0. The data fields keep their last values.
- Flush: when `descarta` is 1, the next state has `saida_valida` at 0, whatever the other inputs are.
  - Flush has priority over capture and hold.
  - An instruction offered in the same cycle is dropped.
  - `entrada_pronta` is still computed by the rule above.
- Both sources equal: both bypass independently, and both operands get the same value.
- Bypass on `wb_endereco_regd == 0` never applies, because the zero register reads 0.

## Timing
- Latency: an instruction accepted at edge k appears at the outputs after edge k, so it is visible in cycle k+1. Throughput is 1 instruction per cycle when `saida_pronta` is held high.
- Reset is checked at the edge while `reset_n` is 0. The reset state is:
  - `saida_valida` 0.
  - `operando1` and `operando2` 0.
  - `saida_regd` 0.
  - `saida_escreve` 0.
  - `fonte1` and `fonte2` 0.
- `entrada_pronta` is 1 in the first cycle after reset.
- A reset asserted in the middle of a hold discards the held instruction. No output retains data.
- `leitura_reg1/2` have zero latency, and the bank read is combinational. The operands therefore reflect the bank state before the capture edge. The bypass covers exactly the write that commits on that same edge.

## Configuration
- `BYPASS_ESCRITA_EN` defined:
  - Capture-time bypass and hold-time operand update are both present, as described above.
- `BYPASS_ESCRITA_EN` undefined:
  - Operands are always `valor_regN`, or 0 for address 0.
  - There is no update during hold.
  - The `wb_*` inputs are ignored.
  - A same-edge write to a source register yields the old value. Upstream must stall for one cycle to avoid this.

## Test plan
- Reset, then capture: `reset_n` held 0 for 2 cycles, then offer sources x5/x6 with the bank returning 0x55/0x66 → next cycle `saida_valida`=1, operands 0x55/0x66, `entrada_pronta`=1 throughout.
- Capture bypass: offer src1=x7 while `wb_permisao_escrita`=1, `wb_endereco_regd`=7, `wb_dado_escrita`=0xABCD, and `valor_reg1`=0x7 → `operando1`=0xABCD. With the macro undefined → `operando1`=0x7.
- Zero register: src1=x0 and src2=x0, with a writeback to x0 of 0xFFFF → both operands 0.
- Stall with update: hold `saida_pronta`=0 for 3 cycles with src2=x9 held, and write 0x1234 to x9 in stall cycle 2 → `entrada_pronta`=0 during the stall, `operando2`=0x1234 from the next cycle, the other fields unchanged. Release → one transfer, then `saida_valida`=0.
- Flush priority: `descarta`=1 while a new instruction is offered and one is held → next cycle `saida_valida`=0; the dropped instruction never appears.
- Back-to-back: 4 instructions on consecutive cycles with `saida_pronta`=1 → 4 consecutive valid outputs in order, with no bubbles.
